// File: rtl/demux1_8_stream_pkg.sv
// Shared widths and buffer state encoding for the 1:8 stream demultiplexer.
package demux1_8_stream_pkg;

  localparam int ARCH_WIDTH = 32;
  localparam int NCH        = 8;
  localparam int SEL_W      = 3;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    DM_EMPTY = 2'd0,
    DM_ONE   = 2'd1,
    DM_FULL  = 2'd2
  } dm_state_e;

endpackage

// File: rtl/demux1_8_stream_if.sv
// Upstream word handshake plus the eight-channel downstream handshake.
interface demux1_8_stream_if #(
  parameter int WIDTH = demux1_8_stream_pkg::ARCH_WIDTH
);
  import demux1_8_stream_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [WIDTH-1:0] in_data;
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment side: produces words and consumes channels.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux1_8_stream_skid_buf2.sv
// Generic 2-entry valid/ready buffer; ready depends on registered state only.
module demux1_8_stream_skid_buf2
  import demux1_8_stream_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  dm_state_e     state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          push;
  logic          pop;

  // A push coinciding with flush is dropped; a pop still completes.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  // State and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DM_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next-state and entry update.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      DM_EMPTY: begin
        if (push) begin
          state_d = DM_ONE;
          head_d  = in_data_i;
        end
      end
      DM_ONE: begin
        if (push && pop) begin
          head_d = in_data_i;
        end else if (push) begin
          state_d = DM_FULL;
          tail_d  = in_data_i;
        end else if (pop) begin
          state_d = DM_EMPTY;
        end
      end
      DM_FULL: begin
        if (pop) begin
          state_d = DM_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = DM_EMPTY;
    endcase
    if (flush_i) begin
      state_d = DM_EMPTY;
    end
  end

  // Handshake outputs from registered state.
  always_comb begin
    in_ready_o  = (state_q != DM_FULL);
    out_valid_o = (state_q != DM_EMPTY);
    out_data_o  = head_q;
  end

endmodule

// File: rtl/demux1_8_stream.sv
// 1:8 stream demultiplexer: FIFO skid buffer, one-hot channel decode, per-channel pop counters.
module demux1_8_stream #(
  parameter int WIDTH = demux1_8_stream_pkg::ARCH_WIDTH,
  parameter int NCH   = demux1_8_stream_pkg::NCH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  demux1_8_stream_if.slave     bus,
  output logic                 busy,
  output logic [NCH*16-1:0]    xfer_cnt
);
  import demux1_8_stream_pkg::*;

  localparam int EW = SEL_W + WIDTH;

  logic [EW-1:0]                buf_in;
  logic [EW-1:0]                buf_out;
  logic                         buf_valid;
  logic                         buf_ready;
  logic                         head_ready;
  logic [SEL_W-1:0]             head_sel;
  logic [NCH-1:0]               out_valid;
  logic                         pop;
  logic [NCH-1:0][CNT_W-1:0]    cnt_q, cnt_d;

  assign buf_in = {bus.in_sel, bus.in_data};

  demux1_8_stream_skid_buf2 #(
    .DW (EW)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (buf_ready),
    .in_data_i   (buf_in),
    .out_valid_o (buf_valid),
    .out_ready_i (head_ready),
    .out_data_o  (buf_out)
  );

  assign head_sel      = buf_out[EW-1 -: SEL_W];
  assign bus.in_ready  = buf_ready;
  assign bus.out_data  = buf_out[WIDTH-1:0];
  assign bus.out_valid = out_valid;
  assign busy          = buf_valid;
  assign xfer_cnt      = cnt_q;
  assign pop           = buf_valid & head_ready;

  // One-hot valid toward the head's channel; only that channel's ready is honoured.
  always_comb begin
    out_valid = '0;
    if (buf_valid) begin
      out_valid[head_sel] = 1'b1;
    end
    head_ready = bus.out_ready[head_sel];
  end

  // Per-channel counter increment on pop, free-running 16-bit wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d[head_sel] = cnt_q[head_sel] + 1'b1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_demux1_8_stream.sv
// Randomized and directed bench for demux1_8_stream against a queue-based reference model.
module tb_demux1_8_stream;
  import demux1_8_stream_pkg::*;

  localparam int W = ARCH_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         busy;
  logic [127:0] xfer_cnt;

  demux1_8_stream_if #(.WIDTH(W)) bus ();

  demux1_8_stream #(.WIDTH(W), .NCH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus.slave),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   sel;
    logic [W-1:0] data;
  } ent_t;

  ent_t        q[$];
  logic [15:0] mcnt [8];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    for (int k = 0; k < 8; k++) mcnt[k] = '0;
  endtask

  task automatic check_outputs();
    logic [127:0] exp_cnt;
    logic [7:0]   exp_valid;
    exp_cnt   = '0;
    exp_valid = '0;
    for (int k = 0; k < 8; k++) exp_cnt[16*k +: 16] = mcnt[k];
    if (q.size() != 0) exp_valid[q[0].sel] = 1'b1;
    check_eq("in_ready", bus.in_ready, q.size() < 2);
    check_eq("busy", busy, q.size() != 0);
    check_eq("out_valid", bus.out_valid, exp_valid);
    if (q.size() != 0) check_eq("out_data", bus.out_data, q[0].data);
    check_eq("xfer_cnt", xfer_cnt, exp_cnt);
  endtask

  // Called with inputs settled while clk is low; advances one clock and the model.
  task automatic step(input bit chk);
    bit   push, pop;
    ent_t e;
    if (chk) check_outputs();
    push = bus.in_valid && (q.size() < 2);
    pop  = (q.size() != 0) && bus.out_ready[q[0].sel];
    e.sel  = bus.in_sel;
    e.data = bus.in_data;
    @(posedge clk);
    if (pop) begin
      mcnt[q[0].sel] = mcnt[q[0].sel] + 16'd1;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (push) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [2:0] s, input logic [W-1:0] d,
                       input logic [7:0] rdy, input bit fl);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = rdy;
    flush         = fl;
  endtask

  // Asserts reset between edges and checks the immediate output values.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    check_outputs();
    check_eq("rst_out_data", bus.out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 3'd0, '0, 8'h00, 0);
    clear_model();
    @(negedge clk);
    check_outputs();
    check_eq("rst_out_data", bus.out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word to channel 5
    drive(1, 3'd5, 32'hDEADBEEF, 8'hFF, 0);
    step(1);
    drive(0, 3'd0, '0, 8'hFF, 0);
    check_eq("single_valid", bus.out_valid, 8'h20);
    step(1);
    step(1);
    check_eq("single_cnt5", xfer_cnt[16*5 +: 16], 16'd1);

    // Back-pressure to FULL, then drain in order
    drive(1, 3'd2, 32'h11, 8'h00, 0);
    step(1);
    drive(1, 3'd6, 32'h22, 8'h00, 0);
    step(1);
    drive(1, 3'd7, 32'h33, 8'h00, 0);
    step(1);
    check_eq("full_ready", bus.in_ready, 1'b0);
    drive(0, 3'd0, '0, 8'h00, 0);
    step(1);
    step(1);
    drive(0, 3'd0, '0, 8'hFF, 0);
    step(1);
    check_eq("drain_second", bus.out_valid, 8'h40);
    step(1);
    step(1);

    // Head-of-line blocking: channel 3 stalled, others ready
    drive(1, 3'd3, 32'h33, 8'hF7, 0);
    step(1);
    drive(1, 3'd6, 32'h66, 8'hF7, 0);
    step(1);
    drive(0, 3'd0, '0, 8'hF7, 0);
    step(1);
    step(1);
    drive(0, 3'd0, '0, 8'hFF, 0);
    step(1);
    step(1);
    step(1);

    // Streaming, 16 back-to-back words
    for (int i = 0; i < 16; i++) begin
      drive(1, 3'(i % 8), W'(i), 8'hFF, 0);
      step(1);
    end
    drive(0, 3'd0, '0, 8'hFF, 0);
    step(1);
    step(1);

    // Flush while FULL with a push attempted and the head popping
    drive(1, 3'd1, 32'hA1, 8'h00, 0);
    step(1);
    drive(1, 3'd4, 32'hA4, 8'h00, 0);
    step(1);
    drive(1, 3'd2, 32'h55, 8'hFF, 1);
    step(1);
    drive(0, 3'd0, '0, 8'hFF, 0);
    step(1);
    step(1);

    // Async reset mid-stream, then a single word again
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'(i + 1), W'(32'h100 + i), 8'h00, 0);
      step(1);
    end
    async_reset();
    drive(1, 3'd5, 32'hDEADBEEF, 8'hFF, 0);
    step(1);
    drive(0, 3'd0, '0, 8'hFF, 0);
    step(1);
    step(1);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), W'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), bit'($urandom_range(0, 63) == 0));
      step(1);
    end
    drive(0, 3'd0, '0, 8'hFF, 0);
    step(1);
    step(1);

    // Counter wrap: exactly 65536 pops on channel 0 from a cleared counter
    async_reset();
    for (int i = 0; i < 65536; i++) begin
      drive(1, 3'd0, W'(i), 8'hFF, 0);
      step(0);
    end
    drive(0, 3'd0, '0, 8'hFF, 0);
    step(0);
    step(1);
    check_eq("wrap_cnt0", xfer_cnt[15:0], 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux1_8_stream.md
Name: demux1_8_stream

Overview:
- 1-to-8 stream demultiplexer: the write/distribute counterpart of the 8:1 read-select mux.
- Accepts one ARCH_WIDTH word plus a 3-bit destination per handshake. Routes it to exactly one of eight consumer channels through a 2-entry skid buffer.
- Used to fan out write-back/result traffic to eight sinks with independent back-pressure, at full throughput and with no combinational ready path.

Parameters:
- WIDTH, default `ARCH_WIDTH (common.vh): data width in bits.
- NCH, default 8: number of output channels; fixed at 8, since sel is 3 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of buffered entries.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  buffer can accept a word.
- in_sel  input  3  destination channel, 0..7.
- in_data  input  WIDTH  payload.
- out_valid  output  8  one-hot; bit k means the head word targets channel k.
- out_ready  input  8  per-channel consumer ready.
- out_data  output  WIDTH  head payload, broadcast to all channels.
- busy  output  1  buffer non-empty.
- xfer_cnt  output  8x16 (128, channel k at bits [16k+15:16k])  per-channel accepted-transfer counters.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - count=0, in_ready=1, out_valid=0, out_data=0, busy=0, all xfer_cnt=0.
  - Any buffered words are discarded, including mid-transfer.
- Storage: two entries {sel, data}, head and tail, plus a state register EMPTY/ONE/FULL.
- Push = in_valid & in_ready. Pop = out_valid[head_sel] & out_ready[head_sel].
- in_ready = (state != FULL). It is a function of registered state only and never depends on in_valid or out_ready.
- out_valid = state!=EMPTY ? (8'b1 << head_sel) : 8'b0.
- out_data = head data when non-empty; holds its last value when EMPTY (don't-care for verification).
- Latency: a word pushed in cycle N is visible on out_valid/out_data in cycle N+1. Minimum 1 cycle, no bypass.
- State transitions:
  - EMPTY: push → ONE, head=in.
  - ONE, push only: → FULL, tail=in.
  - ONE, pop only: → EMPTY.
  - ONE, push+pop: stays ONE, head=in.
  - FULL, pop: → ONE, head=tail. No push is possible (in_ready=0).
  - FULL, no pop: hold.
- Ordering: strict FIFO across all channels. A stalled head blocks later words even if they target other ready channels (no reordering).
- out_ready bits of non-head channels are ignored.
- Throughput: 1 word/cycle sustained when the head channel is always ready.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data and out_valid must hold unchanged.
- Counters:
  - xfer_cnt[head_sel] increments on each pop.
  - 16-bit, wrap 0xFFFF → 0x0000 with no saturation or flag.
  - Cleared only by reset, not by flush.
- flush=1:
  - Next edge: state=EMPTY, discarding all entries.
  - A push in the same cycle is discarded. A pop in the same cycle still completes and is counted.
  - in_ready stays per the current state during the flush cycle.
- busy = (state != EMPTY).

Decomposition:
- Shared package/header (common.vh): ARCH_WIDTH, NCH=8, SEL_W=3, CNT_W=16, state encodings DM_EMPTY=2'd0, DM_ONE=2'd1, DM_FULL=2'd2.
- One natural sub-module: skid_buf2 (generic 2-entry valid/ready buffer carrying {sel,data}). The top handles one-hot decode, ready selection and counters.

Test Plan:
- Reset then single word: in_sel=5, in_data=0xDEADBEEF, out_ready=8'hFF → next cycle out_valid=8'h20, out_data=0xDEADBEEF; popped the same cycle; xfer_cnt[5]=1; busy then 0.
- Back-pressure: push sel=2 (0x11), then sel=6 (0x22), with out_ready=0 → state FULL, in_ready=0, out_valid=8'h04 held stable. Raise out_ready=8'hFF → 0x11 leaves, then 0x22 leaves with out_valid=8'h40; ordering preserved.
- Head-of-line: head sel=3 with out_ready=8'hF7 (bit 3 low) → no pop even though channel 6 is ready; xfer_cnt all unchanged.
- Streaming: 16 back-to-back words, sel=i%8, data=i, out_ready=8'hFF → one pop per cycle, in_ready constantly 1; each xfer_cnt=2.
- Flush when FULL with push attempted and head popping → popped word counted, pushed word dropped, state EMPTY next cycle.
- Async reset mid-stream: assert rst_n=0 between edges → outputs zero immediately; counters 0; first push after release behaves per the single-word case. Also wrap: force 65536 pops on channel 0 → xfer_cnt[0]=0.
